// File: rtl/mem_access.sv
// RV32I memory-access stage: ALU results pass through, loads/stores run one
// request/ack data-bus transaction while the pipeline is stalled.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic        ex_mem_re,
  input  logic        ex_mem_we,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_sdata,
  input  logic        mem_hold,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        mem_exc,
  output logic        stallreq_mem,
  output logic [1:0]  state_dbg
);

  // Bus handshake: dbus_req rises at most one request at a time and its
  // we/addr/be/wdata stay stable until the cycle dbus_ack=1 is sampled.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

  state_t state, state_next;
  logic [31:0] rdata_q;
  logic [CW-1:0] tmo_cnt;
  logic timed_out;

  logic mem_op, legal, go, abort;
  logic [3:0] be_next;
  logic [31:0] wdata_next, load_fmt;
  logic [7:0] lane_byte;
  logic [15:0] lane_half;

  assign mem_op = ex_mem_re | ex_mem_we;
  assign go = mem_op & legal;
  assign abort = TMO_EN && (state == REQ) && !dbus_ack && (tmo_cnt == TMO_LAST);
  assign state_dbg = state;

  always_comb begin
    legal = 1'b0;
    case (ex_funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~ex_mem_addr[0];
      3'b010:  legal = (ex_mem_addr[1:0] == 2'b00);
      3'b100:  legal = ex_mem_re;
      3'b101:  legal = ex_mem_re & ~ex_mem_addr[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    be_next = 4'b1111;
    wdata_next = ex_mem_sdata;
    case (ex_funct3[1:0])
      2'b00: begin
        be_next = 4'b0001 << ex_mem_addr[1:0];
        wdata_next = {4{ex_mem_sdata[7:0]}};
      end
      2'b01: begin
        be_next = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{ex_mem_sdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane_byte = dbus_rdata[{ex_mem_addr[1:0], 3'b000} +: 8];
  assign lane_half = ex_mem_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

  always_comb begin
    load_fmt = dbus_rdata;
    case (ex_funct3)
      3'b000:  load_fmt = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_fmt = {24'd0, lane_byte};
      3'b001:  load_fmt = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_fmt = {16'd0, lane_half};
      default: load_fmt = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = REQ;
      REQ:     if (dbus_ack || abort) state_next = DONE;
      DONE:    if (!mem_hold) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_wd = ex_wd;
    mem_wreg = ex_wreg;
    mem_wdata = ex_wdata;
    mem_exc = 1'b0;
    stallreq_mem = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          mem_wreg = 1'b0;
          if (legal) stallreq_mem = 1'b1;
          else       mem_exc = 1'b1;
        end
      end
      REQ: begin
        mem_wreg = 1'b0;
        stallreq_mem = 1'b1;
      end
      DONE: begin
        mem_wdata = ex_mem_re ? rdata_q : ex_wdata;
        if (timed_out) begin
          mem_wreg = 1'b0;
          mem_exc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Load formatting uses the ex_* fields, which the stall keeps stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbus_req <= 1'b0;
      dbus_we <= 1'b0;
      dbus_addr <= 32'd0;
      dbus_be <= 4'd0;
      dbus_wdata <= 32'd0;
      rdata_q <= 32'd0;
      tmo_cnt <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            dbus_req <= 1'b1;
            dbus_we <= ex_mem_we;
            dbus_addr <= {ex_mem_addr[31:2], 2'b00};
            dbus_be <= be_next;
            dbus_wdata <= wdata_next;
            tmo_cnt <= '0;
            timed_out <= 1'b0;
          end
        end
        REQ: begin
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            if (ex_mem_re) rdata_q <= load_fmt;
          end else if (abort) begin
            dbus_req <= 1'b0;
            timed_out <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads, stores, illegal
// accesses, timeout, async reset mid-transfer and downstream hold.
module tb_mem_access;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] ex_wd = '0;
  logic ex_wreg = 1'b0;
  logic [31:0] ex_wdata = '0;
  logic ex_mem_re = 1'b0, ex_mem_we = 1'b0;
  logic [2:0] ex_funct3 = '0;
  logic [31:0] ex_mem_addr = '0, ex_mem_sdata = '0;
  logic mem_hold = 1'b0;
  logic dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0] dbus_be;
  logic dbus_ack = 1'b0;
  logic [31:0] dbus_rdata = '0;
  logic [4:0] mem_wd;
  logic mem_wreg, mem_exc, stallreq_mem;
  logic [31:0] mem_wdata;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_funct3(ex_funct3),
    .ex_mem_addr(ex_mem_addr), .ex_mem_sdata(ex_mem_sdata), .mem_hold(mem_hold),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_exc(mem_exc), .stallreq_mem(stallreq_mem),
    .state_dbg(state_dbg)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled 3 later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_op();
    ex_mem_re = 1'b0; ex_mem_we = 1'b0; dbus_ack = 1'b0; mem_hold = 1'b0;
    ex_wreg = 1'b0;
  endtask

  task automatic test_reset();
    ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h55;
    cyc(); cyc(); #3;
    checks++; if (dbus_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0h exp 0", dbus_req); end
    checks++; if (dbus_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0h exp 0", dbus_we); end
    checks++; if (dbus_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", dbus_addr); end
    checks++; if (dbus_be !== 4'h0) begin errors++; $display("FAIL rst_be: got %h exp 0", dbus_be); end
    checks++; if (dbus_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h exp 0", dbus_wdata); end
    checks++; if (stallreq_mem !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0h exp 0", stallreq_mem); end
    checks++; if (mem_exc !== 1'b0) begin errors++; $display("FAIL rst_exc: got %0h exp 0", mem_exc); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", state_dbg); end
    checks++; if ({mem_wd, mem_wreg, mem_wdata} !== {5'd3, 1'b1, 32'h55}) begin errors++; $display("FAIL rst_pass: got %0d/%0d/%h exp 3/1/55", mem_wd, mem_wreg, mem_wdata); end
    cyc(); rst = 1'b1;
  endtask

  task automatic test_passthrough();
    cyc(); clear_op(); ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234; #3;
    checks++; if ({mem_wd, mem_wreg, mem_wdata} !== {5'd5, 1'b1, 32'h1234}) begin errors++; $display("FAIL add_pass: got %0d/%0d/%h exp 5/1/1234", mem_wd, mem_wreg, mem_wdata); end
    checks++; if (stallreq_mem !== 1'b0 || dbus_req !== 1'b0) begin errors++; $display("FAIL add_idle: got stall %0d req %0d exp 0/0", stallreq_mem, dbus_req); end
    cyc(); #3;
    checks++; if (dbus_req !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL add_nobus: got req %0d state %0d exp 0/0", dbus_req, state_dbg); end
  endtask

  task automatic test_lb();
    int stalls = 0;
    cyc(); ex_mem_re = 1'b1; ex_funct3 = 3'b000; ex_mem_addr = 32'h103;
    ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'h0; #3;
    if (stallreq_mem) stalls++;
    checks++; if (mem_wreg !== 1'b0 || dbus_req !== 1'b0) begin errors++; $display("FAIL lb_issue: got wreg %0d req %0d exp 0/0", mem_wreg, dbus_req); end
    cyc(); #3; if (stallreq_mem) stalls++;
    checks++; if ({dbus_req, dbus_we, dbus_addr, dbus_be} !== {1'b1, 1'b0, 32'h100, 4'b1000}) begin errors++; $display("FAIL lb_bus: got req %0d we %0d addr %h be %b exp 1/0/100/1000", dbus_req, dbus_we, dbus_addr, dbus_be); end
    cyc(); #3; if (stallreq_mem) stalls++;
    cyc(); dbus_ack = 1'b1; dbus_rdata = 32'h80FFFFFF; #3; if (stallreq_mem) stalls++;
    checks++; if (dbus_req !== 1'b1 || dbus_addr !== 32'h100) begin errors++; $display("FAIL lb_hold: got req %0d addr %h exp 1/100", dbus_req, dbus_addr); end
    cyc(); dbus_ack = 1'b0; #3;
    checks++; if ({stallreq_mem, mem_wreg, mem_exc, mem_wdata} !== {1'b0, 1'b1, 1'b0, 32'hFFFFFF80}) begin errors++; $display("FAIL lb_done: got stall %0d wreg %0d exc %0d data %h exp 0/1/0/ffffff80", stallreq_mem, mem_wreg, mem_exc, mem_wdata); end
    checks++; if (stalls !== 4 || dbus_req !== 1'b0) begin errors++; $display("FAIL lb_stalls: got %0d req %0d exp 4/0", stalls, dbus_req); end
    cyc(); clear_op(); #3;
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL lb_idle: got %0d exp 0", state_dbg); end
  endtask

  task automatic test_sh();
    int cycles = 1;
    cyc(); ex_mem_we = 1'b1; ex_funct3 = 3'b001; ex_mem_addr = 32'h202;
    ex_mem_sdata = 32'hABCD1234; ex_wreg = 1'b0; ex_wdata = 32'h202; #3;
    checks++; if (stallreq_mem !== 1'b1) begin errors++; $display("FAIL sh_issue: got stall %0d exp 1", stallreq_mem); end
    cyc(); dbus_ack = 1'b1; cycles++; #3;
    checks++; if ({dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata} !== {1'b1, 1'b1, 4'b1100, 32'h200, 32'h12341234}) begin errors++; $display("FAIL sh_bus: got req %0d we %0d be %b addr %h wdata %h exp 1/1/1100/200/12341234", dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata); end
    cyc(); dbus_ack = 1'b0; cycles++; #3;
    checks++; if ({state_dbg, stallreq_mem, mem_wreg, mem_exc} !== {2'd2, 1'b0, 1'b0, 1'b0} || cycles !== 3) begin errors++; $display("FAIL sh_done: got state %0d stall %0d wreg %0d exc %0d cyc %0d exp 2/0/0/0/3", state_dbg, stallreq_mem, mem_wreg, mem_exc, cycles); end
    cyc(); clear_op();
  endtask

  task automatic run_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata, input string name);
    cyc(); ex_mem_we = 1'b1; ex_funct3 = f3; ex_mem_addr = addr; ex_mem_sdata = sdata;
    cyc(); dbus_ack = 1'b1; #3;
    checks++; if ({dbus_be, dbus_wdata, dbus_addr} !== {exp_be, exp_wdata, addr & 32'hFFFFFFFC}) begin errors++; $display("FAIL %s: got be %b wdata %h addr %h exp %b/%h/%h", name, dbus_be, dbus_wdata, dbus_addr, exp_be, exp_wdata, addr & 32'hFFFFFFFC); end
    cyc(); dbus_ack = 1'b0;
    cyc(); clear_op();
  endtask

  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [31:0] exp_data, input string name);
    cyc(); ex_mem_re = 1'b1; ex_funct3 = f3; ex_mem_addr = addr; ex_wreg = 1'b1; ex_wdata = 32'h0;
    cyc(); dbus_ack = 1'b1; dbus_rdata = rdata;
    cyc(); dbus_ack = 1'b0; dbus_rdata = 32'h0; #3;
    checks++; if (mem_wdata !== exp_data || mem_wreg !== 1'b1) begin errors++; $display("FAIL %s: got data %h wreg %0d exp %h/1", name, mem_wdata, mem_wreg, exp_data); end
    cyc(); clear_op();
  endtask

  task automatic test_formats();
    run_load(3'b001, 32'h102, 32'h80017FFF, 32'hFFFF8001, "lh_hi");
    run_load(3'b101, 32'h102, 32'h80017FFF, 32'h00008001, "lhu_hi");
    run_load(3'b001, 32'h100, 32'h80017FFF, 32'h00007FFF, "lh_lo");
    run_load(3'b100, 32'h101, 32'h0000A500, 32'h000000A5, "lbu_1");
    run_load(3'b000, 32'h100, 32'h0000007F, 32'h0000007F, "lb_pos");
    run_load(3'b010, 32'h104, 32'hCAFEF00D, 32'hCAFEF00D, "lw");
    run_store(3'b000, 32'h201, 32'h1234565A, 4'b0010, 32'h5A5A5A5A, "sb_1");
    run_store(3'b001, 32'h200, 32'h9999BEEF, 4'b0011, 32'hBEEFBEEF, "sh_lo");
    run_store(3'b010, 32'h204, 32'hCAFEBABE, 4'b1111, 32'hCAFEBABE, "sw");
  endtask

  task automatic test_illegal();
    logic [2:0] f3 [4] = '{3'b010, 3'b001, 3'b100, 3'b011};
    logic [31:0] ad [4] = '{32'h301, 32'h203, 32'h200, 32'h300};
    logic we [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cyc(); ex_mem_re = ~we[i]; ex_mem_we = we[i]; ex_funct3 = f3[i]; ex_mem_addr = ad[i]; ex_wreg = ~we[i]; #3;
      checks++; if ({dbus_req, mem_exc, mem_wreg, stallreq_mem} !== 4'b0100) begin errors++; $display("FAIL illegal_%0d: got req %0d exc %0d wreg %0d stall %0d exp 0/1/0/0", i, dbus_req, mem_exc, mem_wreg, stallreq_mem); end
      cyc(); #3;
      checks++; if (dbus_req !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL illegal_idle_%0d: got req %0d state %0d exp 0/0", i, dbus_req, state_dbg); end
      clear_op();
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    cyc(); ex_mem_re = 1'b1; ex_funct3 = 3'b010; ex_mem_addr = 32'h400; ex_wreg = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(); #3;
      if (dbus_req) req_cycles++;
    end
    checks++; if (req_cycles !== 4) begin errors++; $display("FAIL tmo_req_cycles: got %0d exp 4", req_cycles); end
    // Two edges after the 4th REQ cycle the stage has left DONE; re-check via hold path below.
    clear_op();
    cyc(); ex_mem_re = 1'b1; ex_funct3 = 3'b010; ex_mem_addr = 32'h404; ex_wreg = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    #3;
    checks++; if ({state_dbg, mem_exc, mem_wreg, stallreq_mem, dbus_req} !== {2'd2, 4'b1000}) begin errors++; $display("FAIL tmo_done: got state %0d exc %0d wreg %0d stall %0d req %0d exp 2/1/0/0/0", state_dbg, mem_exc, mem_wreg, stallreq_mem, dbus_req); end
    mem_hold = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'h12345678;
    cyc(); #3;
    checks++; if (state_dbg !== 2'd2 || mem_exc !== 1'b1) begin errors++; $display("FAIL tmo_late_ack: got state %0d exc %0d exp 2/1", state_dbg, mem_exc); end
    mem_hold = 1'b0; dbus_ack = 1'b0;
    cyc(); clear_op(); dbus_ack = 1'b1; #3;
    cyc(); dbus_ack = 1'b0; #3;
    checks++; if (state_dbg !== 2'd0 || dbus_req !== 1'b0) begin errors++; $display("FAIL tmo_stray_ack: got state %0d req %0d exp 0/0", state_dbg, dbus_req); end
  endtask

  task automatic test_reset_mid();
    cyc(); ex_mem_re = 1'b1; ex_funct3 = 3'b010; ex_mem_addr = 32'h500; ex_wreg = 1'b1;
    cyc(); #3;
    checks++; if (dbus_req !== 1'b1) begin errors++; $display("FAIL rmid_req: got %0d exp 1", dbus_req); end
    cyc(); rst = 1'b0; #1;
    checks++; if (dbus_req !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL rmid_async: got req %0d state %0d exp 0/0", dbus_req, state_dbg); end
    cyc(); rst = 1'b1; #3;
    checks++; if ({state_dbg, stallreq_mem, dbus_req} !== {2'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL rmid_idle: got state %0d stall %0d req %0d exp 0/1/0", state_dbg, stallreq_mem, dbus_req); end
    cyc(); dbus_ack = 1'b1; dbus_rdata = 32'hDEADBEEF; #3;
    checks++; if (dbus_req !== 1'b1 || dbus_addr !== 32'h500) begin errors++; $display("FAIL rmid_reissue: got req %0d addr %h exp 1/500", dbus_req, dbus_addr); end
    cyc(); dbus_ack = 1'b0; #3;
    checks++; if (mem_wdata !== 32'hDEADBEEF || mem_wreg !== 1'b1) begin errors++; $display("FAIL rmid_done: got %h wreg %0d exp deadbeef/1", mem_wdata, mem_wreg); end
    cyc(); clear_op();
  endtask

  task automatic test_hold();
    cyc(); ex_mem_re = 1'b1; ex_funct3 = 3'b010; ex_mem_addr = 32'h600; ex_wreg = 1'b1;
    cyc(); dbus_ack = 1'b1; dbus_rdata = 32'h11223344;
    cyc(); dbus_ack = 1'b0; dbus_rdata = 32'hFFFFFFFF; mem_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(); #3;
      checks++; if (state_dbg !== 2'd2 || mem_wdata !== 32'h11223344 || stallreq_mem !== 1'b0) begin errors++; $display("FAIL hold_%0d: got state %0d data %h stall %0d exp 2/11223344/0", i, state_dbg, mem_wdata, stallreq_mem); end
    end
    mem_hold = 1'b0;
    cyc(); clear_op(); #3;
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL hold_release: got %0d exp 0", state_dbg); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lb();
    test_sh();
    test_formats();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

endmodule
